mult_div_unit: RTL
==================

// Module: mult_div_unit
// PURPOSE
//  - E-stage multiply/divide unit (MDU) of the P6 pipeline; owns the HI/LO registers.
//  - Generates the start/busy pair that the hazard unit consumes to stall MDU instructions in D.
//  - Executes MULT/MULTU/DIV/DIVU as multi-cycle ops, MTHI/MTLO as single-edge writes, MFHI/MFLO as combinational reads.
// PARAMETERS
//  MULT_CYCLES  5   busy cycles for MULT/MULTU (and MADD* ops when enabled); legal range 1..15
//  DIV_CYCLES   10  busy cycles for DIV/DIVU; legal range 1..15
// PORTS
//  clk      in   1   system clock; all state updates on posedge
//  reset_n  in   1   asynchronous, active-low reset
//  start    in   1   E-stage pulse; high only in the cycle a MULT/MULTU/DIV/DIVU (or MADD*) op is in E
//  MDUOp    in   4   0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MFHI, 6 MFLO, 7 MTHI, 8 MTLO, 9-12 MADD/MADDU/MSUB/MSUBU
//  A        in   32  rs operand (already forwarded)
//  B        in   32  rt operand (already forwarded)
//  busy     out  1   operation in flight
//  HI       out  32  architectural HI register
//  LO       out  32  architectural LO register
//  MDUOut   out  32  MFHI -> HI, MFLO -> LO, all other ops -> 0; combinational
// BEHAVIOUR
//  - Reset (reset_n=0, any time, including mid-operation): HI=0, LO=0, busy=0, counter=0, latched op/operands=0.
//    The in-flight result is discarded. Outputs are valid immediately, without a clock edge.
//  - Start accepted on a posedge with start=1, busy=0, and MDUOp in {1,2,3,4} (or 9-12 when enabled).
//    - At that edge: latch MDUOp, A and B; load counter with MULT_CYCLES or DIV_CYCLES.
//  - busy = (counter != 0). It is high for exactly N cycles after the accepting edge.
//  - Each edge with counter != 0 decrements the counter.
//  - The edge on which the counter goes 1 -> 0 writes HI/LO. busy falls and new HI/LO become visible in the same cycle.
//  - Arithmetic:
//    - MULT: {HI,LO} = $signed(A)*$signed(B), 64-bit.
//    - MULTU: unsigned 64-bit product.
//    - DIV: LO = quotient truncated toward zero; HI = remainder, carrying the sign of the dividend.
//    - DIVU: unsigned quotient and remainder.
//    - DIV with 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
//    - DIV/DIVU with B==0: busy still runs the full DIV_CYCLES; HI and LO are left unchanged.
//  - MTHI/MTLO: on an edge with busy=0, HI<=A (MTHI) or LO<=A (MTLO). No start is required and busy stays 0.
//  - Ignored while busy=1: start and MTHI/MTLO (the hazard unit prevents these cases; the unit must still not corrupt state).
//  - MFHI/MFLO while busy: return the current (old) HI/LO. There is no internal stall.
//  - start with MDUOp in {0,5,6,7,8}: ignored, busy stays 0.
//  - Same-edge case: a new start is legal on the edge after busy falls. Back-to-back ops use the freshly written HI/LO.
//  - Operand/op inputs are don't-care while busy. Only latched copies are used.
// CONFIGURATION
//  MDU_MADD_EN defined:
//   - MDUOp 9 MADD: {HI,LO} += signed A*B.
//   - MDUOp 10 MADDU: {HI,LO} += unsigned A*B.
//   - MDUOp 11 MSUB: {HI,LO} -= signed A*B.
//   - MDUOp 12 MSUBU: {HI,LO} -= unsigned A*B.
//   - All four are accepted on start with MULT_CYCLES latency.
//   - The accumulate uses the {HI,LO} value current at the write edge. The 64-bit wrap-around is discarded silently.
//  MDU_MADD_EN undefined: MDUOp 9-15 behave as NONE, and start with these codes is ignored.
// TESTING
//  - MULT A=0xFFFFFFFE(-2), B=3, start 1 cycle -> busy=1 for 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
//  - MULTU A=0xFFFFFFFF, B=0xFFFFFFFF -> after 5 cycles HI=0xFFFFFFFE, LO=0x00000001.
//  - DIV A=-7(0xFFFFFFF9), B=2 -> busy 10 cycles, then LO=0xFFFFFFFD(-3), HI=0xFFFFFFFF(-1).
//  - DIVU A=100, B=0 after MTHI 0x11 / MTLO 0x22 -> busy 10 cycles; HI=0x11, LO=0x22 unchanged.
//  - Reset mid-operation:
//    - Drive DIV 50/5 start, pull reset_n low 3 cycles later -> busy=0, HI=LO=0 immediately.
//    - No write occurs after reset_n is released.
//  - MTLO 0x1234 with MDUOp=6 on the next cycle -> MDUOut=0x1234.
//  - With MDU_MADD_EN: HI=0, LO=0xFFFFFFFF, then MADDU A=1, B=1 -> HI=1, LO=0.

Source files
------------

// File: rtl/mult_div_unit.sv
// E-stage multiply/divide unit owning HI/LO; multi-cycle MULT/DIV with a busy countdown.
// Define MDU_MADD_EN to add the MADD/MADDU/MSUB/MSUBU accumulate ops (codes 9-12).
`timescale 1ns/1ps

module mult_div_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [3:0]  MDUOp,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic [31:0] MDUOut
);

    typedef enum logic [3:0] {
        OP_NONE  = 4'd0,
        OP_MULT  = 4'd1,
        OP_MULTU = 4'd2,
        OP_DIV   = 4'd3,
        OP_DIVU  = 4'd4,
        OP_MFHI  = 4'd5,
        OP_MFLO  = 4'd6,
        OP_MTHI  = 4'd7,
        OP_MTLO  = 4'd8,
        OP_MADD  = 4'd9,
        OP_MADDU = 4'd10,
        OP_MSUB  = 4'd11,
        OP_MSUBU = 4'd12
    } mdu_op_e;

    mdu_op_e     op_q;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [3:0]  counter;
    logic [31:0] hi_q;
    logic [31:0] lo_q;

    logic        is_mdu_op;
    logic        accept;
    logic        res_wr;
    logic [31:0] res_hi;
    logic [31:0] res_lo;

    logic signed [63:0] prod_s;
    logic [63:0]        prod_u;
    logic [31:0]        a_mag;
    logic [31:0]        b_mag;
    logic [31:0]        q_mag;
    logic [31:0]        r_mag;
    logic [31:0]        quot_s;
    logic [31:0]        rem_s;

    always_comb begin
        is_mdu_op = 1'b0;
        case (MDUOp)
            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: is_mdu_op = 1'b1;
`ifdef MDU_MADD_EN
            OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: is_mdu_op = 1'b1;
`endif
            default: is_mdu_op = 1'b0;
        endcase
    end

    assign busy   = (counter != 4'd0);
    assign accept = start && !busy && is_mdu_op;

    assign prod_s = $signed({{32{op_a[31]}}, op_a}) * $signed({{32{op_b[31]}}, op_b});
    assign prod_u = {32'd0, op_a} * {32'd0, op_b};

    // Signed divide done on magnitudes so 0x80000000 / -1 yields 0x80000000 without overflow.
    assign a_mag  = op_a[31] ? (~op_a + 32'd1) : op_a;
    assign b_mag  = op_b[31] ? (~op_b + 32'd1) : op_b;
    assign q_mag  = a_mag / b_mag;
    assign r_mag  = a_mag % b_mag;
    assign quot_s = (op_a[31] ^ op_b[31]) ? (~q_mag + 32'd1) : q_mag;
    assign rem_s  = op_a[31] ? (~r_mag + 32'd1) : r_mag;

    always_comb begin
        res_wr = 1'b0;
        res_hi = hi_q;
        res_lo = lo_q;
        case (op_q)
            OP_MULT: begin
                {res_hi, res_lo} = prod_s;
                res_wr           = 1'b1;
            end
            OP_MULTU: begin
                {res_hi, res_lo} = prod_u;
                res_wr           = 1'b1;
            end
            OP_DIV: begin
                if (op_b != 32'd0) begin
                    res_hi = rem_s;
                    res_lo = quot_s;
                    res_wr = 1'b1;
                end
            end
            OP_DIVU: begin
                if (op_b != 32'd0) begin
                    res_hi = op_a % op_b;
                    res_lo = op_a / op_b;
                    res_wr = 1'b1;
                end
            end
`ifdef MDU_MADD_EN
            OP_MADD: begin
                {res_hi, res_lo} = {hi_q, lo_q} + prod_s;
                res_wr           = 1'b1;
            end
            OP_MADDU: begin
                {res_hi, res_lo} = {hi_q, lo_q} + prod_u;
                res_wr           = 1'b1;
            end
            OP_MSUB: begin
                {res_hi, res_lo} = {hi_q, lo_q} - prod_s;
                res_wr           = 1'b1;
            end
            OP_MSUBU: begin
                {res_hi, res_lo} = {hi_q, lo_q} - prod_u;
                res_wr           = 1'b1;
            end
`endif
            default: res_wr = 1'b0;
        endcase
    end

    // An in-flight op takes priority, so starts and MTHI/MTLO are dropped while busy.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            op_q    <= OP_NONE;
            op_a    <= 32'd0;
            op_b    <= 32'd0;
            counter <= 4'd0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
        end else if (busy) begin
            counter <= counter - 4'd1;
            if (counter == 4'd1 && res_wr) begin
                hi_q <= res_hi;
                lo_q <= res_lo;
            end
        end else if (accept) begin
            op_q <= mdu_op_e'(MDUOp);
            op_a <= A;
            op_b <= B;
            if (MDUOp == OP_DIV || MDUOp == OP_DIVU) begin
                counter <= 4'(DIV_CYCLES);
            end else begin
                counter <= 4'(MULT_CYCLES);
            end
        end else if (MDUOp == OP_MTHI) begin
            hi_q <= A;
        end else if (MDUOp == OP_MTLO) begin
            lo_q <= A;
        end
    end

    always_comb begin
        MDUOut = 32'd0;
        case (MDUOp)
            OP_MFHI: MDUOut = hi_q;
            OP_MFLO: MDUOut = lo_q;
            default: MDUOut = 32'd0;
        endcase
    end

    assign HI = hi_q;
    assign LO = lo_q;

endmodule
